// File: rtl/fifo_unpacker.sv
// Pops 64-bit words from a synchronous FIFO and serialises each one LSB-first into
// OUT_W-bit lanes on a valid/ready stream, keeping one spare word to hide read latency.
module fifo_unpacker #(
  parameter int DATA_W = 64,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_valid,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       word_cnt,
  output logic              protocol_err
);

  localparam int N     = DATA_W / OUT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N - 1);

  logic [DATA_W-1:0] act_reg, act_reg_n;
  logic              act_valid, act_valid_n;
  logic [CNT_W-1:0]  lane_cnt, lane_cnt_n;
  logic [DATA_W-1:0] spr_reg, spr_reg_n;
  logic              spr_valid, spr_valid_n;
  logic              pending, pending_n;
  logic [15:0]       word_cnt_n;
  logic              protocol_err_n;

  logic fire;
  logic word_done;
  logic arrival;
  logic stray;

  assign fire      = act_valid & m_ready;
  assign word_done = fire & (lane_cnt == LAST_LANE);
  assign arrival   = fifo_valid & pending;
  assign stray     = fifo_valid & ~pending;

  // At most one word may be in flight or parked, so a pop waits on both.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~pending & ~spr_valid;

  always_comb begin
    m_data = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_cnt == CNT_W'(k)) begin
        m_data = act_reg[k*OUT_W +: OUT_W];
      end
    end
  end

  assign m_valid = act_valid;
  assign m_last  = act_valid & (lane_cnt == LAST_LANE);

  always_comb begin
    act_reg_n      = act_reg;
    act_valid_n    = act_valid;
    lane_cnt_n     = lane_cnt;
    spr_reg_n      = spr_reg;
    spr_valid_n    = spr_valid;
    pending_n      = pending;
    word_cnt_n     = word_cnt;
    protocol_err_n = protocol_err | stray;

    if (fire) begin
      lane_cnt_n = word_done ? '0 : lane_cnt + 1'b1;
    end

    if (word_done) begin
      act_valid_n = 1'b0;
      word_cnt_n  = word_cnt + 16'd1;
    end

    // Promotion and arrival never coincide: a parked spare blocks any pop.
    if (word_done && spr_valid) begin
      act_reg_n   = spr_reg;
      act_valid_n = 1'b1;
      lane_cnt_n  = '0;
      spr_valid_n = 1'b0;
    end

    if (arrival) begin
      pending_n = 1'b0;
      if (!act_valid || word_done) begin
        act_reg_n   = fifo_data;
        act_valid_n = 1'b1;
        lane_cnt_n  = '0;
      end else begin
        spr_reg_n   = fifo_data;
        spr_valid_n = 1'b1;
      end
    end

    if (fifo_rd_en) begin
      pending_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_reg      <= '0;
      act_valid    <= 1'b0;
      lane_cnt     <= '0;
      spr_reg      <= '0;
      spr_valid    <= 1'b0;
      pending      <= 1'b0;
      word_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      act_reg      <= act_reg_n;
      act_valid    <= act_valid_n;
      lane_cnt     <= lane_cnt_n;
      spr_reg      <= spr_reg_n;
      spr_valid    <= spr_valid_n;
      pending      <= pending_n;
      word_cnt     <= word_cnt_n;
      protocol_err <= protocol_err_n;
    end
  end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Read-side consumer for the synchronous 64-bit FIFO: pops words through the FIFO's rd_en/empty/out_valid interface and serialises each word into narrow lanes on a valid/ready stream. It keeps one spare word slot so that, under continuous m_ready, lanes of consecutive words stream without bubbles despite the FIFO's one-cycle read latency.

## Interface
- DATA_W, 64, FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output lane width; N = DATA_W/OUT_W ≥ 2 lanes per word.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop request to FIFO.
- fifo_data  in  DATA_W  FIFO read data, valid when fifo_valid=1.
- fifo_valid  in  1  FIFO read-data strobe, one cycle after an accepted pop.
- m_data  out  OUT_W  current output lane.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts lane when m_valid&m_ready.
- m_last  out  1  high with the final lane (index N-1) of a word.
- word_cnt  out  16  count of fully emitted words, wraps 0xFFFF→0.
- protocol_err  out  1  sticky: fifo_valid seen with no read outstanding.

## Operation
- State: active slot (act_reg, act_valid, lane counter width clog2(N)), spare slot (spr_reg, spr_valid), pending flag (one pop outstanding).
- Invariant: pending + spr_valid ≤ 1.
- Pop: fifo_rd_en = !rst & !fifo_empty & !pending & !spr_valid. Combinational; pending sets on the edge where fifo_rd_en=1.
- Lane order LSB-first: lane k = act_reg[k*OUT_W +: OUT_W]; m_data = lane[lane_cnt], m_valid = act_valid, m_last = act_valid & (lane_cnt==N-1). m_data/m_valid/m_last depend only on registers, with no combinational path from m_ready.
- Handshake fire = m_valid & m_ready: lane_cnt increments; on the last lane, lane_cnt wraps to 0, word_cnt increments, and the active slot is released.
- Arrival (fifo_valid & pending): clear pending. If the active slot is empty or being released this cycle, load act_reg with lane_cnt=0; otherwise load spr_reg and set spr_valid.
- Release with spr_valid=1: spr_reg moves into the active slot, lane_cnt=0, spr_valid cleared. This occurs in the same edge as the release.
- Stray fifo_valid (pending=0): data discarded, protocol_err set until rst.
- m_valid held and m_data stable while m_ready=0, across any number of stall cycles.

## Timing
- Reset values: fifo_rd_en 0 (forced while rst=1), m_valid 0, m_data 0, m_last 0, word_cnt 0, protocol_err 0, pending/act_valid/spr_valid 0, lane_cnt 0.
- Reset mid-operation: all words held or in flight are dropped. First pop can occur in the first cycle after rst deasserts.
- Latency: fifo_rd_en high in cycle t → fifo_valid in t+1 → m_valid high in t+2 (word into empty active slot).
- Throughput: with m_ready=1 and FIFO never empty, one lane per cycle with no gap between words. A pop is issued as soon as the spare slot frees, so the next word is always resident before the current word's last lane fires.
- Backpressure: with m_ready=0, at most 2 words are held (active + spare). No further pops are issued while spr_valid=1.
- Simultaneous events: last-lane fire + arrival in the same cycle → arrival goes directly to the active slot (spare stays empty). Last-lane fire + spare valid → promote. A pop may assert in the same cycle as promotion only if spr_valid was already 0.
- fifo_empty=1 → fifo_rd_en=0; no other effect.

## Test plan
- Single word 0x0807060504030201 after reset, m_ready=1 → rd_en at t, m_valid from t+2, m_data 01,02,…,08 on consecutive cycles, m_last only on 08, word_cnt=1.
- Two words pre-loaded, m_ready=1 → 16 consecutive m_valid cycles with no gap, m_last on cycles 8 and 16, word_cnt=2, exactly 2 pops.
- Three words pre-loaded, m_ready=0 for 20 cycles → exactly 2 pops, m_valid=1 with m_data=lane0 of word0 stable. Release m_ready → 24 lanes in order, word_cnt=3.
- Random m_ready (50%) over 100 random words → output stream equals scoreboard lane sequence, pending+spr_valid never exceeds 1, protocol_err stays 0.
- fifo_valid pulse with no pop outstanding → protocol_err=1 and held, no m_valid produced from that data. rst → protocol_err=0.
- rst asserted after lane 3 of a word with spare valid → all outputs at reset values immediately. After release, next FIFO word's lane0 appears first and word_cnt restarts from 0.
